// File: rtl/mmu_client_arbiter.sv
// Shares one MMU alloc/free request FIFO pair between four clients by round-robin, and routes
// MMU responses back to the issuing client, one response in flight per path.
module mmu_client_arbiter #(
  parameter int unsigned NCLI  = 4,
  parameter int unsigned TAG_W = 11,
  parameter int unsigned ID_W  = 13,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned IDX_W = 15,
  parameter int unsigned FR_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCLI-1:0]         cl_alloc_valid,
  input  logic [NCLI*TAG_W-1:0]   cl_alloc_tag,
  input  logic [NCLI*CNT_W-1:0]   cl_alloc_cnt,
  output logic [NCLI-1:0]         cl_alloc_ready,
  input  logic [NCLI-1:0]         cl_free_valid,
  input  logic [NCLI*TAG_W-1:0]   cl_free_tag,
  input  logic [NCLI*IDX_W-1:0]   cl_free_idx,
  input  logic [NCLI*CNT_W-1:0]   cl_free_cnt,
  output logic [NCLI-1:0]         cl_free_ready,
  output logic                    alloc_req_submit,
  output logic [ID_W-1:0]         alloc_req_id,
  output logic [CNT_W-1:0]        alloc_req_page_count,
  input  logic                    alloc_req_fifo_full,
  output logic                    free_req_submit,
  output logic [ID_W-1:0]         free_req_id,
  output logic [IDX_W-1:0]        free_req_page_idx,
  output logic [CNT_W-1:0]        free_req_page_count,
  input  logic                    free_req_fifo_full,
  output logic                    alloc_rsp_pop,
  input  logic                    alloc_rsp_fifo_not_empty,
  input  logic [ID_W-1:0]         alloc_rsp_id,
  input  logic [IDX_W-1:0]        alloc_rsp_page_idx,
  input  logic                    alloc_rsp_fail,
  input  logic [FR_W-1:0]         alloc_rsp_fail_reason,
  output logic                    free_rsp_pop,
  input  logic                    free_rsp_fifo_not_empty,
  input  logic [ID_W-1:0]         free_rsp_id,
  input  logic                    free_rsp_fail,
  input  logic [FR_W-1:0]         free_rsp_fail_reason,
  output logic [NCLI-1:0]         cl_alloc_rsp_valid,
  output logic [TAG_W-1:0]        cl_alloc_rsp_tag,
  output logic [IDX_W-1:0]        cl_alloc_rsp_page_idx,
  output logic                    cl_alloc_rsp_fail,
  output logic [FR_W-1:0]         cl_alloc_rsp_fail_reason,
  input  logic [NCLI-1:0]         cl_alloc_rsp_ready,
  output logic [NCLI-1:0]         cl_free_rsp_valid,
  output logic [TAG_W-1:0]        cl_free_rsp_tag,
  output logic                    cl_free_rsp_fail,
  output logic [FR_W-1:0]         cl_free_rsp_fail_reason,
  input  logic [NCLI-1:0]         cl_free_rsp_ready
);

  localparam int unsigned CliW = 2;

  typedef enum logic [1:0] {StIdle, StPop, StHold} rsp_st_e;

  // Request arbitration
  logic [CliW-1:0] a_ptr_q, a_ptr_d, f_ptr_q, f_ptr_d;
  logic [CliW-1:0] a_sel, f_sel, a_cand, f_cand;
  logic            a_gnt, f_gnt;

  always_comb begin
    a_gnt  = 1'b0;
    a_sel  = a_ptr_q;
    a_cand = a_ptr_q;
    f_gnt  = 1'b0;
    f_sel  = f_ptr_q;
    f_cand = f_ptr_q;
    for (int unsigned k = 0; k < NCLI; k++) begin
      a_cand = a_ptr_q + CliW'(k);
      if (!a_gnt && cl_alloc_valid[a_cand]) begin
        a_gnt = 1'b1;
        a_sel = a_cand;
      end
      f_cand = f_ptr_q + CliW'(k);
      if (!f_gnt && cl_free_valid[f_cand]) begin
        f_gnt = 1'b1;
        f_sel = f_cand;
      end
    end
    a_gnt   = a_gnt & ~alloc_req_fifo_full & ~rst;
    f_gnt   = f_gnt & ~free_req_fifo_full & ~rst;
    a_ptr_d = a_gnt ? a_sel + CliW'(1) : a_ptr_q;
    f_ptr_d = f_gnt ? f_sel + CliW'(1) : f_ptr_q;
  end

  always_comb begin
    cl_alloc_ready = '0;
    cl_free_ready  = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      cl_alloc_ready[i] = a_gnt && (a_sel == CliW'(i));
      cl_free_ready[i]  = f_gnt && (f_sel == CliW'(i));
    end
  end

  assign alloc_req_submit     = a_gnt;
  assign alloc_req_id         = {a_sel, cl_alloc_tag[a_sel*TAG_W +: TAG_W]};
  assign alloc_req_page_count = cl_alloc_cnt[a_sel*CNT_W +: CNT_W];
  assign free_req_submit      = f_gnt;
  assign free_req_id          = {f_sel, cl_free_tag[f_sel*TAG_W +: TAG_W]};
  assign free_req_page_idx    = cl_free_idx[f_sel*IDX_W +: IDX_W];
  assign free_req_page_count  = cl_free_cnt[f_sel*CNT_W +: CNT_W];

  // Response paths: the FIFO read data is only valid the cycle after the pop
  rsp_st_e          ar_st_q, ar_st_d, fr_st_q, fr_st_d;
  logic [ID_W-1:0]  ar_id_q, ar_id_d, fr_id_q, fr_id_d;
  logic [IDX_W-1:0] ar_idx_q, ar_idx_d;
  logic             ar_fail_q, ar_fail_d, fr_fail_q, fr_fail_d;
  logic [FR_W-1:0]  ar_fr_q, ar_fr_d, fr_fr_q, fr_fr_d;
  logic [CliW-1:0]  ar_cli, fr_cli;

  assign ar_cli = ar_id_q[ID_W-1:TAG_W];
  assign fr_cli = fr_id_q[ID_W-1:TAG_W];

  always_comb begin
    ar_st_d   = ar_st_q;
    ar_id_d   = ar_id_q;
    ar_idx_d  = ar_idx_q;
    ar_fail_d = ar_fail_q;
    ar_fr_d   = ar_fr_q;
    unique case (ar_st_q)
      StIdle: if (alloc_rsp_fifo_not_empty) ar_st_d = StPop;
      StPop: begin
        ar_st_d   = StHold;
        ar_id_d   = alloc_rsp_id;
        ar_idx_d  = alloc_rsp_page_idx;
        ar_fail_d = alloc_rsp_fail;
        ar_fr_d   = alloc_rsp_fail_reason;
      end
      StHold: if (cl_alloc_rsp_ready[ar_cli]) ar_st_d = StIdle;
      default: ar_st_d = StIdle;
    endcase
  end

  always_comb begin
    fr_st_d   = fr_st_q;
    fr_id_d   = fr_id_q;
    fr_fail_d = fr_fail_q;
    fr_fr_d   = fr_fr_q;
    unique case (fr_st_q)
      StIdle: if (free_rsp_fifo_not_empty) fr_st_d = StPop;
      StPop: begin
        fr_st_d   = StHold;
        fr_id_d   = free_rsp_id;
        fr_fail_d = free_rsp_fail;
        fr_fr_d   = free_rsp_fail_reason;
      end
      StHold: if (cl_free_rsp_ready[fr_cli]) fr_st_d = StIdle;
      default: fr_st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_ptr_q   <= '0;
      f_ptr_q   <= '0;
      ar_st_q   <= StIdle;
      ar_id_q   <= '0;
      ar_idx_q  <= '0;
      ar_fail_q <= 1'b0;
      ar_fr_q   <= '0;
      fr_st_q   <= StIdle;
      fr_id_q   <= '0;
      fr_fail_q <= 1'b0;
      fr_fr_q   <= '0;
    end else begin
      a_ptr_q   <= a_ptr_d;
      f_ptr_q   <= f_ptr_d;
      ar_st_q   <= ar_st_d;
      ar_id_q   <= ar_id_d;
      ar_idx_q  <= ar_idx_d;
      ar_fail_q <= ar_fail_d;
      ar_fr_q   <= ar_fr_d;
      fr_st_q   <= fr_st_d;
      fr_id_q   <= fr_id_d;
      fr_fail_q <= fr_fail_d;
      fr_fr_q   <= fr_fr_d;
    end
  end

  assign alloc_rsp_pop = !rst && (ar_st_q == StIdle) && alloc_rsp_fifo_not_empty;
  assign free_rsp_pop  = !rst && (fr_st_q == StIdle) && free_rsp_fifo_not_empty;

  always_comb begin
    cl_alloc_rsp_valid = '0;
    cl_free_rsp_valid  = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      cl_alloc_rsp_valid[i] = !rst && (ar_st_q == StHold) && (ar_cli == CliW'(i));
      cl_free_rsp_valid[i]  = !rst && (fr_st_q == StHold) && (fr_cli == CliW'(i));
    end
  end

  assign cl_alloc_rsp_tag         = ar_id_q[TAG_W-1:0];
  assign cl_alloc_rsp_page_idx    = ar_idx_q;
  assign cl_alloc_rsp_fail        = ar_fail_q;
  assign cl_alloc_rsp_fail_reason = ar_fr_q;
  assign cl_free_rsp_tag          = fr_id_q[TAG_W-1:0];
  assign cl_free_rsp_fail         = fr_fail_q;
  assign cl_free_rsp_fail_reason  = fr_fr_q;

endmodule
